// File: rtl/led_pwm_fader.sv
// Three-channel LED PWM driver: each channel ramps linearly toward the
// brightness selected by its colour bit, one step per RAMP_DIV clocks.
module led_pwm_fader #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned ON_LEVEL = 255,
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] colour,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic       busy
);

  localparam int unsigned         MAX_LEVEL = (1 << PWM_BITS) - 1;
  localparam int unsigned         DIV_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'(MAX_LEVEL - 1);
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] ON_LVL    = PWM_BITS'(ON_LEVEL);

  logic [2:0]          colour_q;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                tick;
  logic [PWM_BITS-1:0] level_q [3];
  logic [PWM_BITS-1:0] level_d [3];
  logic [PWM_BITS-1:0] target  [3];
  logic [2:0]          pwm_q, pwm_d;
  logic                busy_c;

  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    tick      = (div_cnt_q == DIV_LAST);
    busy_c    = 1'b0;
    pwm_d     = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      target[c]  = colour_q[c] ? ON_LVL : '0;
      level_d[c] = level_q[c];
      pwm_d[c]   = (level_q[c] > pwm_cnt_q);
      // single-step moves toward the target cannot overshoot or wrap
      if (tick) begin
        if (level_q[c] < target[c]) begin
          level_d[c] = level_q[c] + 1'b1;
        end else if (level_q[c] > target[c]) begin
          level_d[c] = level_q[c] - 1'b1;
        end
      end
      busy_c = busy_c | (level_q[c] != target[c]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      colour_q  <= '0;
      pwm_cnt_q <= '0;
      div_cnt_q <= '0;
      pwm_q     <= '0;
      for (int unsigned c = 0; c < 3; c++) begin
        level_q[c] <= '0;
      end
    end else if (enable) begin
      colour_q  <= colour;
      pwm_cnt_q <= pwm_cnt_d;
      div_cnt_q <= div_cnt_d;
      pwm_q     <= pwm_d;
      for (int unsigned c = 0; c < 3; c++) begin
        level_q[c] <= level_d[c];
      end
    end else begin
      pwm_q <= '0;
    end
  end

  assign red   = pwm_q[0];
  assign green = pwm_q[1];
  assign blue  = pwm_q[2];
  assign busy  = busy_c;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench for led_pwm_fader: three parameterisations share one stimulus
// stream; a cycle model predicts {red,green,blue,busy} of each after every edge.
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic [2:0] colour = 3'b111;
  logic [2:0] red_w, green_w, blue_w, busy_w;

  always #5 clk = ~clk;

  led_pwm_fader u_dflt (
    .clk(clk), .rst(rst), .enable(enable), .colour(colour),
    .red(red_w[0]), .green(green_w[0]), .blue(blue_w[0]), .busy(busy_w[0])
  );

  led_pwm_fader #(.ON_LEVEL(64), .RAMP_DIV(1)) u_duty (
    .clk(clk), .rst(rst), .enable(enable), .colour(colour),
    .red(red_w[1]), .green(green_w[1]), .blue(blue_w[1]), .busy(busy_w[1])
  );

  led_pwm_fader #(.RAMP_DIV(1)) u_fast (
    .clk(clk), .rst(rst), .enable(enable), .colour(colour),
    .red(red_w[2]), .green(green_w[2]), .blue(blue_w[2]), .busy(busy_w[2])
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model, one slot per instance
  int         p_on  [3] = '{255, 64, 255};
  int         p_div [3] = '{4, 1, 1};
  logic [2:0] m_cq  [3];
  int         m_pwm [3];
  int         m_div [3];
  int         m_lvl [3][3];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cq[d] = '0; m_pwm[d] = 0; m_div[d] = 0;
      for (int c = 0; c < 3; c++) m_lvl[d][c] = 0;
    end
  endtask

  task automatic model_edge(output logic [11:0] e);
    logic [2:0] out;
    logic       bz;
    int         tgt;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      out = '0;
      if (!rst) begin
        m_cq[d] = '0; m_pwm[d] = 0; m_div[d] = 0;
        for (int c = 0; c < 3; c++) m_lvl[d][c] = 0;
      end else if (enable) begin
        for (int c = 0; c < 3; c++) begin
          out[c] = (m_lvl[d][c] > m_pwm[d]);
          tgt = m_cq[d][c] ? p_on[d] : 0;
          if (m_div[d] == p_div[d] - 1) begin
            if (m_lvl[d][c] < tgt) m_lvl[d][c]++;
            else if (m_lvl[d][c] > tgt) m_lvl[d][c]--;
          end
        end
        m_pwm[d] = (m_pwm[d] == 254) ? 0 : m_pwm[d] + 1;
        m_div[d] = (m_div[d] + 1) % p_div[d];
        m_cq[d]  = colour;
      end
      bz = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tgt = m_cq[d][c] ? p_on[d] : 0;
        if (m_lvl[d][c] != tgt) bz = 1'b1;
      end
      e[d*4 +: 4] = {out[0], out[1], out[2], bz};
    end
  endtask

  logic [11:0] exp_q[$];

  task automatic step();
    logic [11:0] e;
    model_edge(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("sb%0d", d), 32'({red_w[d], green_w[d], blue_w[d], busy_w[d]}), 32'(e[d*4 +: 4]));
    end
  endtask

  task automatic wait_all_idle(input string tag);
    int n = 0;
    while (busy_w != 3'b000 && n < 3000) begin
      step();
      n++;
    end
    check(tag, 32'(busy_w), 32'd0);
  endtask

  int n, cnt, cnt2;
  logic [2:0] cyc_seq [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};

  initial begin
    model_reset();

    // reset held with all colours requested
    repeat (4) step();
    for (int d = 0; d < 3; d++)
      check($sformatf("rst_hold%0d", d), 32'({red_w[d], green_w[d], blue_w[d], busy_w[d]}), 32'd0);

    // full red ramp on the default instance
    rst = 1'b1;
    colour = 3'b001;
    step();
    check("ramp_busy_rise", 32'(busy_w[0]), 32'd1);
    n = 1; cnt = 0;
    while (busy_w[0] && n < 3000) begin
      step();
      n++;
      cnt += 32'(green_w[0]) + 32'(blue_w[0]);
    end
    check("ramp_time", 32'(n), 32'd1020);
    check("ramp_gb_off", 32'(cnt), 32'd0);
    cnt = 0;
    repeat (255) begin step(); cnt += 32'(red_w[0]); end
    check("red_full_on", 32'(cnt), 32'd255);

    // duty on ON_LEVEL=64 instance
    colour = 3'b010;
    n = 0;
    do begin step(); n++; end while (busy_w[1] && n < 500);
    check("duty_settle", 32'(busy_w[1]), 32'd0);
    cnt = 0; cnt2 = 0;
    repeat (255) begin
      step();
      cnt  += 32'(green_w[1]);
      cnt2 += 32'(red_w[1]) + 32'(blue_w[1]);
    end
    check("duty_green", 32'(cnt), 32'd64);
    check("duty_rb_off", 32'(cnt2), 32'd0);

    // reversal on the fast instance
    colour = 3'b000;
    wait_all_idle("idle_pre_rev");
    colour = 3'b100;
    repeat (100) step();
    colour = 3'b000;
    n = 0;
    do begin step(); n++; end while (busy_w[2] && n < 400);
    check("reversal_time", 32'(n), 32'd101);

    // asynchronous reset in the middle of a ramp
    colour = 3'b111;
    repeat (30) step();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++)
      check($sformatf("rst_async%0d", d), 32'({red_w[d], green_w[d], blue_w[d], busy_w[d]}), 32'd0);
    repeat (3) step();

    // enable hold stretches the ramp by exactly the held cycles
    rst = 1'b1;
    colour = 3'b001;
    step();
    n = 1;
    while (n < 300) begin step(); n++; end
    enable = 1'b0;
    step();
    check("hold_outs_off", 32'({red_w, green_w, blue_w}), 32'd0);
    repeat (49) step();
    n += 50;
    enable = 1'b1;
    while (busy_w[0] && n < 3000) begin step(); n++; end
    check("hold_ramp_time", 32'(n), 32'd1070);

    // upstream cycling every clock
    for (int i = 0; i < 300; i++) begin
      colour = cyc_seq[i % 6];
      step();
    end
    colour = 3'b000;
    wait_all_idle("idle_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
